// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an ID-stage instruction into ALUCon/operands, holds them
// in an ID/EX register that drives an external combinational ALU, and captures the
// ALU result plus zero/branch/destination info into an EX/MEM register.
module alu_issue_stage #(
    parameter int         DATA_W     = 32,
    parameter logic [5:0] CUSTOM_OPC = 6'b011100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        alu_con,
    output logic [DATA_W-1:0] alu_data_a,
    output logic [DATA_W-1:0] alu_data_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic              ex_zero,
    output logic              ex_branch_taken,
    output logic              ex_reg_write,
    output logic [4:0]        ex_dest,
    output logic              ex_illegal
);
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0011, ALU_NOR = 4'b0100, ALU_XOR = 4'b0101,
                           ALU_INC = 4'b0110, ALU_DEC = 4'b0111, ALU_CPL = 4'b1000;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_LW  = 6'b100011,
                           OP_SW    = 6'b101011, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_XORI  = 6'b001110, OP_BEQ  = 6'b000100, OP_BNE = 6'b000101;

    logic [5:0]        w_opc, w_funct;
    logic [4:0]        w_rt, w_rd;
    logic [DATA_W-1:0] w_sext, w_zext;
    logic              w_unused_fields;

    assign w_opc   = id_instr[31:26];
    assign w_funct = id_instr[5:0];
    assign w_rt    = id_instr[20:16];
    assign w_rd    = id_instr[15:11];
    assign w_sext  = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
    assign w_zext  = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
    // rs number and shamt are not needed: operands arrive already read/forwarded
    assign w_unused_fields = ^{id_instr[25:21], id_instr[10:6]};

    logic [3:0]        w_con;
    logic [DATA_W-1:0] w_a, w_b;
    logic [4:0]        w_dest;
    logic              w_write, w_beq, w_bne, w_illegal;

    // Decode opcode/funct into ALUCon, operand selection and writeback info
    always_comb begin
        w_con     = ALU_ADD;
        w_a       = id_rs_data;
        w_b       = id_rt_data;
        w_dest    = '0;
        w_write   = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_illegal = 1'b0;
        case (w_opc)
            OP_RTYPE: begin
                w_dest  = w_rd;
                w_write = 1'b1;
                case (w_funct)
                    6'b100000, 6'b100001: w_con = ALU_ADD;
                    6'b100010, 6'b100011: w_con = ALU_SUB;
                    6'b100100:            w_con = ALU_AND;
                    6'b100101:            w_con = ALU_OR;
                    6'b100110:            w_con = ALU_XOR;
                    6'b100111:            w_con = ALU_NOR;
                    default:              w_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW: begin
                w_b = w_sext; w_dest = w_rt; w_write = 1'b1;
            end
            OP_SW:   w_b = w_sext;
            OP_ANDI: begin w_con = ALU_AND; w_b = w_zext; w_dest = w_rt; w_write = 1'b1; end
            OP_ORI:  begin w_con = ALU_OR;  w_b = w_zext; w_dest = w_rt; w_write = 1'b1; end
            OP_XORI: begin w_con = ALU_XOR; w_b = w_zext; w_dest = w_rt; w_write = 1'b1; end
            OP_BEQ:  begin w_con = ALU_SUB; w_beq = 1'b1; end
            OP_BNE:  begin w_con = ALU_SUB; w_bne = 1'b1; end
            default: begin
                // custom opcode compared here so a clash with a fixed opcode cannot duplicate an item
                if (w_opc == CUSTOM_OPC) begin
                    w_b = '0; w_dest = w_rd; w_write = 1'b1;
                    case (w_funct)
                        6'd0:    w_con = ALU_INC;
                        6'd1:    w_con = ALU_DEC;
                        6'd2:    w_con = ALU_CPL;
                        default: w_illegal = 1'b1;
                    endcase
                end else begin
                    w_illegal = 1'b1;
                end
            end
        endcase
        // undecodable ops travel as add 0+0 with no side effects
        if (w_illegal) begin
            w_con = ALU_ADD; w_a = '0; w_b = '0; w_dest = '0;
            w_write = 1'b0; w_beq = 1'b0; w_bne = 1'b0;
        end
    end

    assign id_ready = ~reset & ~stall & ~flush;

    logic              r_valid, r_illegal, r_write, r_beq, r_bne;
    logic [3:0]        r_con;
    logic [DATA_W-1:0] r_a, r_b;
    logic [4:0]        r_dest;

    // ID/EX: flush beats stall; stall holds; otherwise load decode or a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0; r_illegal <= 1'b0; r_write <= 1'b0; r_beq <= 1'b0; r_bne <= 1'b0;
            r_con <= '0; r_a <= '0; r_b <= '0; r_dest <= '0;
        end else if (flush) begin
            r_valid <= 1'b0; r_illegal <= 1'b0; r_write <= 1'b0; r_beq <= 1'b0; r_bne <= 1'b0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_illegal <= id_valid & w_illegal;
            r_write   <= id_valid & w_write;
            r_beq     <= id_valid & w_beq;
            r_bne     <= id_valid & w_bne;
            r_con     <= w_con;
            r_a       <= w_a;
            r_b       <= w_b;
            r_dest    <= w_dest;
        end
    end

    // a bubble presents and 0 + 0 to the ALU so its Result is 0
    assign alu_con    = r_valid ? r_con : ALU_AND;
    assign alu_data_a = r_valid ? r_a : '0;
    assign alu_data_b = r_valid ? r_b : '0;

    logic w_ex_load, w_alu_zero;
    assign w_ex_load  = r_valid & ~stall;
    assign w_alu_zero = (alu_result == '0);

    logic              r_ex_valid, r_ex_zero, r_ex_taken, r_ex_write, r_ex_illegal;
    logic [DATA_W-1:0] r_ex_result;
    logic [4:0]        r_ex_dest;

    // EX/MEM: capture ALU result for live entries; bubbles clear control, keep data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0; r_ex_zero <= 1'b0; r_ex_taken <= 1'b0; r_ex_write <= 1'b0;
            r_ex_illegal <= 1'b0; r_ex_result <= '0; r_ex_dest <= '0;
        end else if (w_ex_load) begin
            r_ex_valid   <= ~r_illegal;
            r_ex_illegal <= r_illegal;
            r_ex_result  <= alu_result;
            r_ex_zero    <= w_alu_zero;
            r_ex_taken   <= (r_beq & w_alu_zero) | (r_bne & ~w_alu_zero);
            r_ex_write   <= r_write;
            r_ex_dest    <= r_dest;
        end else begin
            r_ex_valid <= 1'b0; r_ex_taken <= 1'b0; r_ex_write <= 1'b0; r_ex_illegal <= 1'b0;
        end
    end

    assign ex_valid        = r_ex_valid;
    assign ex_result       = r_ex_result;
    assign ex_zero         = r_ex_zero;
    assign ex_branch_taken = r_ex_taken;
    assign ex_reg_write    = r_ex_write;
    assign ex_dest         = r_ex_dest;
    assign ex_illegal      = r_ex_illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU closes the loop, a scoreboard queue
// holds expected EX/MEM entries, per-scenario tasks check operands and control.
module tb_alu_issue_stage;
    localparam int         DW   = 32;
    localparam logic [5:0] COPC = 6'b011100;

    logic          clk = 1'b0, reset = 1'b1, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic          id_ready;
    logic [31:0]   id_instr = '0;
    logic [DW-1:0] id_rs_data = '0, id_rt_data = '0;
    logic [3:0]    alu_con;
    logic [DW-1:0] alu_data_a, alu_data_b, alu_result, ex_result;
    logic          ex_valid, ex_zero, ex_branch_taken, ex_reg_write, ex_illegal;
    logic [4:0]    ex_dest;
    int            errors = 0, checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        zero, taken, write, illegal;
        logic [4:0]  dest;
    } exp_t;
    exp_t sb[$];

    alu_issue_stage #(.DATA_W(DW), .CUSTOM_OPC(COPC)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .stall(stall), .flush(flush), .alu_con(alu_con), .alu_data_a(alu_data_a),
        .alu_data_b(alu_data_b), .alu_result(alu_result), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_zero(ex_zero), .ex_branch_taken(ex_branch_taken),
        .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // external ALU
    always_comb begin
        case (alu_con)
            4'd0: alu_result = alu_data_a & alu_data_b;
            4'd1: alu_result = alu_data_a | alu_data_b;
            4'd2: alu_result = alu_data_a + alu_data_b;
            4'd3: alu_result = alu_data_a - alu_data_b;
            4'd4: alu_result = ~(alu_data_a | alu_data_b);
            4'd5: alu_result = alu_data_a ^ alu_data_b;
            4'd6: alu_result = alu_data_a + 1;
            4'd7: alu_result = alu_data_a - 1;
            4'd8: alu_result = ~alu_data_a;
            default: alu_result = '0;
        endcase
    end

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rd);
        return {6'b0, 5'd1, 5'd2, rd, 5'd0, f};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction
    function automatic logic [31:0] cust(input logic [5:0] f, input logic [4:0] rd);
        return {COPC, 5'd1, 5'd0, rd, 5'd0, f};
    endfunction

    // reference: architectural result of an instruction on the given operands
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [31:0] se, ze, d;
        e  = '0;
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        d  = rs - rt;
        case (ins[31:26])
            6'h00: begin
                e.write = 1'b1; e.dest = ins[15:11];
                case (ins[5:0])
                    6'h20, 6'h21: e.res = rs + rt;
                    6'h22, 6'h23: e.res = d;
                    6'h24: e.res = rs & rt;
                    6'h25: e.res = rs | rt;
                    6'h26: e.res = rs ^ rt;
                    6'h27: e.res = ~(rs | rt);
                    default: e.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h23: begin e.res = rs + se; e.write = 1'b1; e.dest = ins[20:16]; end
            6'h2b: e.res = rs + se;
            6'h0c: begin e.res = rs & ze; e.write = 1'b1; e.dest = ins[20:16]; end
            6'h0d: begin e.res = rs | ze; e.write = 1'b1; e.dest = ins[20:16]; end
            6'h0e: begin e.res = rs ^ ze; e.write = 1'b1; e.dest = ins[20:16]; end
            6'h04: begin e.res = d; e.taken = (d == 0); end
            6'h05: begin e.res = d; e.taken = (d != 0); end
            COPC: begin
                e.write = 1'b1; e.dest = ins[15:11];
                case (ins[5:0])
                    6'd0: e.res = rs + 1;
                    6'd1: e.res = rs - 1;
                    6'd2: e.res = ~rs;
                    default: e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin e.res = '0; e.write = 1'b0; e.dest = '0; end
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        id_valid = 1'b1; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
    endtask

    // pops one expectation per retirement (valid or illegal) and compares the EX/MEM fields
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ex_valid || ex_illegal) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got=retire res %h dest %0d exp=none", ex_result, ex_dest);
                end else begin
                    e = sb.pop_front();
                    checks += 6;
                    if (ex_result !== e.res) begin errors++; $display("FAIL sb_result got=%h exp=%h", ex_result, e.res); end
                    if (ex_zero !== e.zero) begin errors++; $display("FAIL sb_zero got=%b exp=%b", ex_zero, e.zero); end
                    if (ex_branch_taken !== e.taken) begin errors++; $display("FAIL sb_taken got=%b exp=%b", ex_branch_taken, e.taken); end
                    if (ex_reg_write !== e.write) begin errors++; $display("FAIL sb_write got=%b exp=%b", ex_reg_write, e.write); end
                    if (ex_illegal !== e.illegal) begin errors++; $display("FAIL sb_illegal got=%b exp=%b", ex_illegal, e.illegal); end
                    if (ex_valid !== !e.illegal) begin errors++; $display("FAIL sb_valid got=%b exp=%b", ex_valid, !e.illegal); end
                    if (e.write) begin
                        checks++;
                        if (ex_dest !== e.dest) begin errors++; $display("FAIL sb_dest got=%0d exp=%0d", ex_dest, e.dest); end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", id_ready); end
        if (alu_con !== 4'b0000) begin errors++; $display("FAIL rst_con got=%h exp=0", alu_con); end
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ex_valid); end
        if (ex_result !== '0) begin errors++; $display("FAIL rst_result got=%h exp=0", ex_result); end
        if (ex_zero !== 1'b0) begin errors++; $display("FAIL rst_zero got=%b exp=0", ex_zero); end
        reset = 1'b0;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", id_ready); end
    endtask

    // back-to-back R-type ops; first entry is the add 5+7 case
    task automatic test_rtype();
        logic [5:0] f[9]  = '{6'h20, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
        logic [3:0] ec[9] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd1, 4'd5, 4'd4};
        logic [31:0] a[9], b[9];
        for (int i = 0; i < 9; i++) begin
            a[i] = (i == 0) ? 32'd5 : $urandom;
            b[i] = (i == 0) ? 32'd7 : $urandom;
        end
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks += 3;
                if (alu_con !== ec[i-1]) begin errors++; $display("FAIL rtype_con[%0d] got=%h exp=%h", i-1, alu_con, ec[i-1]); end
                if (alu_data_a !== a[i-1]) begin errors++; $display("FAIL rtype_a[%0d] got=%h exp=%h", i-1, alu_data_a, a[i-1]); end
                if (alu_data_b !== b[i-1]) begin errors++; $display("FAIL rtype_b[%0d] got=%h exp=%h", i-1, alu_data_b, b[i-1]); end
            end
            if (i < 9) begin
                issue(rtype(f[i], 5'(i + 3)), a[i], b[i]);
                sb.push_back(model(rtype(f[i], 5'(i + 3)), a[i], b[i]));
            end else id_valid = 1'b0;
        end
    endtask

    // immediate forms: zero- vs sign-extension on the B operand
    task automatic test_imm();
        logic [31:0] ins[6] = '{itype(6'h0c, 5'd4, 16'hFFFF), itype(6'h08, 5'd5, 16'hFFFF),
                                itype(6'h23, 5'd6, 16'h8000), itype(6'h2b, 5'd7, 16'h0004),
                                itype(6'h0d, 5'd8, 16'h00F0), itype(6'h0e, 5'd9, 16'hA5A5)};
        logic [31:0] rs[6]  = '{32'h1234_5678, 32'd1, 32'h0001_0000, 32'h100, 32'h0F, 32'hFFFF_0000};
        logic [31:0] eb[6]  = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_8000, 32'h4, 32'hF0, 32'h0000_A5A5};
        logic [3:0]  ec[6]  = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd1, 4'd5};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks += 3;
                if (alu_con !== ec[i-1]) begin errors++; $display("FAIL imm_con[%0d] got=%h exp=%h", i-1, alu_con, ec[i-1]); end
                if (alu_data_a !== rs[i-1]) begin errors++; $display("FAIL imm_a[%0d] got=%h exp=%h", i-1, alu_data_a, rs[i-1]); end
                if (alu_data_b !== eb[i-1]) begin errors++; $display("FAIL imm_b[%0d] got=%h exp=%h", i-1, alu_data_b, eb[i-1]); end
            end
            if (i < 6) begin
                issue(ins[i], rs[i], 32'hDEAD_BEEF);
                sb.push_back(model(ins[i], rs[i], 32'hDEAD_BEEF));
            end else id_valid = 1'b0;
        end
    endtask

    // beq/bne and the custom unary ops
    task automatic test_branch_custom();
        logic [31:0] ins[6] = '{itype(6'h04, 5'd0, 16'h0010), itype(6'h05, 5'd0, 16'h0010),
                                itype(6'h05, 5'd0, 16'h0010), cust(6'd0, 5'd20),
                                cust(6'd1, 5'd21), cust(6'd2, 5'd22)};
        logic [31:0] rs[6]  = '{32'd9, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rt[6]  = '{32'd9, 32'd9, 32'd3, 32'h55, 32'h55, 32'h55};
        logic [31:0] eb[6]  = '{32'd9, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0};
        logic [3:0]  ec[6]  = '{4'd3, 4'd3, 4'd3, 4'd6, 4'd7, 4'd8};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks += 3;
                if (alu_con !== ec[i-1]) begin errors++; $display("FAIL bc_con[%0d] got=%h exp=%h", i-1, alu_con, ec[i-1]); end
                if (alu_data_a !== rs[i-1]) begin errors++; $display("FAIL bc_a[%0d] got=%h exp=%h", i-1, alu_data_a, rs[i-1]); end
                if (alu_data_b !== eb[i-1]) begin errors++; $display("FAIL bc_b[%0d] got=%h exp=%h", i-1, alu_data_b, eb[i-1]); end
            end
            if (i < 6) begin
                issue(ins[i], rs[i], rt[i]);
                sb.push_back(model(ins[i], rs[i], rt[i]));
            end else id_valid = 1'b0;
        end
    endtask

    // 3-cycle stall holds an op in ID/EX; it retires exactly once afterwards
    task automatic test_stall();
        @(negedge clk);
        issue(rtype(6'h20, 5'd9), 32'd100, 32'd23);
        sb.push_back(model(rtype(6'h20, 5'd9), 32'd100, 32'd23));
        @(negedge clk);
        stall = 1'b1;
        issue(rtype(6'h22, 5'd10), 32'd50, 32'd8);
        #1;
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", id_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 4;
            if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_exv[%0d] got=%b exp=0", k, ex_valid); end
            if (alu_con !== 4'd2) begin errors++; $display("FAIL stall_con[%0d] got=%h exp=2", k, alu_con); end
            if (alu_data_a !== 32'd100) begin errors++; $display("FAIL stall_a[%0d] got=%h exp=64", k, alu_data_a); end
            if (alu_data_b !== 32'd23) begin errors++; $display("FAIL stall_b[%0d] got=%h exp=17", k, alu_data_b); end
        end
        stall = 1'b0;
        sb.push_back(model(rtype(6'h22, 5'd10), 32'd50, 32'd8));
        @(negedge clk);
        id_valid = 1'b0;
        checks++;
        if (alu_con !== 4'd3) begin errors++; $display("FAIL stall_next_con got=%h exp=3", alu_con); end
        repeat (2) @(negedge clk);
    endtask

    // flush alone still retires the current entry; stall+flush drops it
    task automatic test_flush();
        @(negedge clk);
        issue(rtype(6'h25, 5'd12), 32'hF0, 32'h0F);
        sb.push_back(model(rtype(6'h25, 5'd12), 32'hF0, 32'h0F));
        @(negedge clk);
        flush = 1'b1;
        issue(rtype(6'h20, 5'd13), 32'd1, 32'd1);
        #1;
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        checks++;
        if (alu_con !== 4'd0 || alu_data_a !== '0) begin errors++; $display("FAIL flush_bubble got=%h/%h exp=0/0", alu_con, alu_data_a); end
        @(negedge clk);
        issue(rtype(6'h20, 5'd11), 32'd1, 32'd1);
        @(negedge clk);
        id_valid = 1'b0; stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        checks += 2;
        if (alu_con !== 4'd0 || alu_data_a !== '0) begin errors++; $display("FAIL sflush_bubble got=%h/%h exp=0/0", alu_con, alu_data_a); end
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL sflush_exv got=%b exp=0", ex_valid); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        issue(32'hFC00_1234, 32'hDEAD, 32'hBEEF);
        sb.push_back(model(32'hFC00_1234, 32'hDEAD, 32'hBEEF));
        @(negedge clk);
        id_valid = 1'b0;
        checks += 3;
        if (alu_con !== 4'd2) begin errors++; $display("FAIL ill_con got=%h exp=2", alu_con); end
        if (alu_data_a !== '0) begin errors++; $display("FAIL ill_a got=%h exp=0", alu_data_a); end
        if (alu_data_b !== '0) begin errors++; $display("FAIL ill_b got=%h exp=0", alu_data_b); end
        @(negedge clk);
        checks += 2;
        if (ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got=%b exp=1", ex_illegal); end
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL ill_valid got=%b exp=0", ex_valid); end
        @(negedge clk);
        checks++;
        if (ex_illegal !== 1'b0) begin errors++; $display("FAIL ill_oneshot got=%b exp=0", ex_illegal); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        issue(rtype(6'h20, 5'd13), 32'd3, 32'd4);
        sb.push_back(model(rtype(6'h20, 5'd13), 32'd3, 32'd4));
        @(negedge clk);
        issue(itype(6'h04, 5'd0, 16'h1), 32'd5, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b0;
        @(negedge clk);
        checks += 9;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", ex_valid); end
        if (ex_result !== '0) begin errors++; $display("FAIL mrst_result got=%h exp=0", ex_result); end
        if (ex_zero !== 1'b0) begin errors++; $display("FAIL mrst_zero got=%b exp=0", ex_zero); end
        if (ex_branch_taken !== 1'b0) begin errors++; $display("FAIL mrst_taken got=%b exp=0", ex_branch_taken); end
        if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL mrst_write got=%b exp=0", ex_reg_write); end
        if (ex_dest !== '0) begin errors++; $display("FAIL mrst_dest got=%0d exp=0", ex_dest); end
        if (ex_illegal !== 1'b0) begin errors++; $display("FAIL mrst_illegal got=%b exp=0", ex_illegal); end
        if (alu_con !== 4'd0) begin errors++; $display("FAIL mrst_con got=%h exp=0", alu_con); end
        if (id_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got=%b exp=0", id_ready); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork monitor(); join_none
        test_reset();
        test_rtype();
        test_imm();
        test_branch_custom();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
